// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM encoding,
// byte-lane geometry and the request/response bundles of the lane aligner.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int OFF_W     = 2;
    localparam int WORD_W    = NUM_LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [2:0]        f3;
        logic [OFF_W-1:0]  off;
        logic [WORD_W-1:0] wdata;
    } lane_req_t;

    typedef struct packed {
        logic [NUM_LANES-1:0]             be;
        logic [NUM_LANES-1:0][LANE_W-1:0] wdata;
        logic [WORD_W-1:0]                rdata;
        logic                             err;
    } lane_rsp_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and lane data, load
// extract with sign/zero extension, and misaligned/illegal-funct3 detection.
module dmem_lane_align
    import mem_pkg::*;
(
    input  lane_req_t         req,
    input  logic [WORD_W-1:0] rd_word,
    output lane_rsp_t         rsp
);

    logic                             illegal;
    logic                             misaligned;
    logic                             err;
    logic [NUM_LANES-1:0]             be;
    logic [NUM_LANES-1:0][LANE_W-1:0] wd;
    logic [WORD_W-1:0]                shifted;
    logic [WORD_W-1:0]                ext;

    always_comb begin
        illegal = 1'b0;
        case (req.f3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = req.we;
            default:          illegal = 1'b1;
        endcase
        misaligned = ((req.f3[1:0] == 2'b01) && req.off[0]) ||
                     ((req.f3[1:0] == 2'b10) && (req.off != '0));
    end

    assign err = illegal | misaligned;

    // Half stores replicate the low half into both halves of the word.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [OFF_W-1:0] LI = OFF_W'(i);
        assign be[i] = (req.f3[1:0] == 2'b00) ? (req.off == LI) :
                       (req.f3[1:0] == 2'b01) ? (req.off[1] == LI[1]) : 1'b1;
        assign wd[i] = (req.f3[1:0] == 2'b00) ? req.wdata[LANE_W-1:0] :
                       (req.f3[1:0] == 2'b01) ? req.wdata[(i % 2)*LANE_W +: LANE_W] :
                                                req.wdata[i*LANE_W +: LANE_W];
    end

    assign shifted = rd_word >> {req.off, 3'b000};

    always_comb begin
        ext = '0;
        case (req.f3)
            F3_B:    ext = {{(WORD_W-LANE_W){shifted[LANE_W-1]}}, shifted[LANE_W-1:0]};
            F3_BU:   ext = {{(WORD_W-LANE_W){1'b0}}, shifted[LANE_W-1:0]};
            F3_H:    ext = {{(WORD_W-2*LANE_W){shifted[2*LANE_W-1]}}, shifted[2*LANE_W-1:0]};
            F3_HU:   ext = {{(WORD_W-2*LANE_W){1'b0}}, shifted[2*LANE_W-1:0]};
            F3_W:    ext = rd_word;
            default: ext = '0;
        endcase
    end

    assign rsp.err   = err;
    assign rsp.be    = be & {NUM_LANES{~err}};
    assign rsp.wdata = wd;
    assign rsp.rdata = err ? '0 : ext;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one outstanding load/store, fixed latency,
// stall to the pipeline while busy, registered one-cycle response.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_f3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [IDX_W+1:0]  addr_q;

    logic              accept;
    logic              enter_resp;
    logic [IDX_W+1:0]  cur_addr;
    logic [IDX_W-1:0]  cur_idx;
    lane_req_t         cur;
    lane_rsp_t         lrsp;
    logic [31:0]       rd_word;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              unused_addr;
    assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];

    assign req_ready  = (state == ST_IDLE);
    assign accept     = req_ready & req_valid;
    assign stall      = accept | (state == ST_BUSY);
    assign enter_resp = (state_nx == ST_RESP);

    // In IDLE the aligner sees the live request (store path and LATENCY==1
    // loads); afterwards it sees the latched one.
    always_comb begin
        cur_addr  = addr_q;
        cur.we    = we_q;
        cur.f3    = f3_q;
        cur.wdata = req_wdata;
        if (state == ST_IDLE) begin
            cur_addr = req_addr[IDX_W+1:0];
            cur.we   = req_we;
            cur.f3   = req_f3;
        end
        cur.off = cur_addr[OFF_W-1:0];
    end

    assign cur_idx = cur_addr[IDX_W+1:2];
    assign rd_word = mem[cur_idx];

    dmem_lane_align u_align (
        .req     (cur),
        .rd_word (rd_word),
        .rsp     (lrsp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (req_valid) state_nx = (LATENCY == 1) ? ST_RESP : ST_BUSY;
            ST_BUSY: if (cnt == CNT_W'(1)) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            we_q   <= 1'b0;
            f3_q   <= 3'b000;
            addr_q <= '0;
        end else if (accept) begin
            cnt    <= CNT_INIT;
            we_q   <= req_we;
            f3_q   <= req_f3;
            addr_q <= req_addr[IDX_W+1:0];
        end else if (state == ST_BUSY) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= enter_resp;
            if (enter_resp) begin
                resp_err   <= lrsp.err;
                resp_rdata <= cur.we ? '0 : lrsp.rdata;
            end
        end
    end

    // Array is never reset; stores land on the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst_n && accept && req_we && !lrsp.err) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lrsp.be[i]) mem[cur_idx][i*LANE_W +: LANE_W] <= lrsp.wdata[i];
            end
        end
    end

endmodule
